// File: rtl/ucsbece154a_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a small TX FIFO that a
// serializer FSM drains LSB-first onto tx_o; STATUS exposes level/busy/overflow.
module ucsbece154a_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h2000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_i,
    input  logic [31:0] wd_i,
    input  logic        we_i,
    output logic [31:0] rd_o,
    output logic        tx_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          ovf;
        logic          busy;
        logic          empty;
        logic          full;
    } status_t;

    state_t        state;
    logic [7:0]    shift;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic    sel;
    logic    wr_data;
    logic    wr_stat;
    logic    empty;
    logic    full;
    logic    baud_end;
    logic    pop;
    logic    push;
    logic    ovf_set;
    logic    ovf_clr;
    logic [7:0] head;
    status_t status;
    logic    unused_bits;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign sel     = (a_i[31:4] == BASE_ADDR[31:4]);
    assign wr_data = sel && we_i && (a_i[3:2] == 2'd0);
    assign wr_stat = sel && we_i && (a_i[3:2] == 2'd1);

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign baud_end = (baud == '0);
    assign head     = mem[rd_ptr];

    // The FSM pops either from IDLE or at the end of a stop bit, so frames chain.
    assign pop     = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign push    = wr_data && (!full || pop);
    assign ovf_set = wr_data && full && !pop;
    assign ovf_clr = wr_stat && wd_i[3];

    assign unused_bits = ^{a_i[1:0], wd_i[31:8]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wd_i[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Overflow set takes priority over a software clear.
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (!empty) begin
                        shift <= head;
                        baud  <= BAUD_MAX;
                        state <= START;
                        tx_o  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= BAUD_MAX;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_o    <= shift[0];
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud  <= BAUD_MAX;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_o    <= shift[1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        if (!empty) begin
                            shift <= head;
                            baud  <= BAUD_MAX;
                            state <= START;
                            tx_o  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx_o  <= 1'b1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path (combinational, zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        status.count = count;
        status.ovf   = ovf;
        status.busy  = (state != IDLE);
        status.empty = empty;
        status.full  = full;
    end

    always_comb begin
        rd_o = '0;
        if (sel && (a_i[3:2] == 2'd1))
            rd_o[CW+3:0] = status;
    end

endmodule

// File: doc/ucsbece154a_uart_tx.md
# ucsbece154a_uart_tx

Memory-mapped 8N1 UART transmitter that acts as a responder on the processor data bus, next to `ucsbece154a_mem` in `ucsbece154a_top`. The processor stores bytes to a data register; the block queues them in a small FIFO and serializes them LSB-first on `tx_o`. A status register reports FIFO level, busy state and a sticky overflow flag to software polling with loads.

## Interface
- `BASE_ADDR`, 32'h2000_0000: register block base; must be 16-byte aligned.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two and ≥2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low (0 = reset).
- `a_i`  in  32  bus byte address.
- `wd_i`  in  32  bus write data.
- `we_i`  in  1  bus write enable.
- `rd_o`  out  32  bus read data, combinational.
- `tx_o`  out  1  serial output, registered, idles high.

## Operation
- Select: `sel = (a_i[31:4] == BASE_ADDR[31:4])`. When not selected, writes are ignored and `rd_o = 0`.
- Registers, decoded on `a_i[3:2]`:
  - 0 TXDATA: a write pushes `wd_i[7:0]`; a read returns 0.
  - 1 STATUS: a read returns {zeros, count[..:0] at bit 4, ovf bit 3, busy bit 2, empty bit 1, full bit 0}. A write with `wd_i[3]=1` clears ovf.
  - 2, 3: reads return 0; writes are ignored.
- FIFO:
  - Circular buffer with read and write pointers of width `$clog2(FIFO_DEPTH)`, which wrap naturally.
  - `count` is `$clog2(FIFO_DEPTH)+1` bits wide.
- Push when full with no pop in the same cycle: data is dropped, count is unchanged, and ovf is set to 1 (sticky).
- Push and pop in the same cycle: both happen, count is unchanged. This holds when full, so a push while full and popping is accepted.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty: pop the head into an 8-bit shift register, reload the baud counter to `CLKS_PER_BIT-1`, go to START.
  - START: drive `tx_o=0`.
  - DATA: drive `tx_o=shift[0]`. A 3-bit bit index counts 0..7. The shift register shifts right when each bit period ends.
  - STOP: drive `tx_o=1`.
  - The baud counter decrements every cycle. At 0 it reloads and advances:
    - START → DATA.
    - DATA → DATA, or → STOP after bit 7.
    - STOP → START if the FIFO is non-empty (pop at the same edge, no idle gap), else → IDLE.
- `busy = (state != IDLE)`.
- Simultaneous software clear of ovf and an overflowing push: the set wins (ovf = 1).

## Timing
- Reset values, applied asynchronously while `reset=0`:
  - `tx_o=1`, state IDLE.
  - FIFO empty (pointers and count 0).
  - ovf 0, shift register 0, baud counter 0.
  - `rd_o` then reads STATUS as 32'h2 when selected.
- Reset asserted mid-frame aborts the frame immediately (`tx_o=1` without waiting for a clock) and discards the FIFO contents.
- Write latency:
  - A push at edge N with the FSM in IDLE pops at edge N+1.
  - `tx_o` falls after edge N+1.
  - `busy` and `empty` reflect the new state after the edge that changes them.
- Frame length is exactly `10*CLKS_PER_BIT` cycles: start, 8 data bits LSB-first, 1 stop.
- Back-to-back frames have no gap between one stop bit and the next start bit.
- Throughput: bytes still queued when the FSM pops are sent in consecutive frames.
- `rd_o` is purely combinational from `a_i` and current state. It has zero-cycle read latency, matching the single-cycle data memory.

## Test plan
Benches run with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset, release, read STATUS → `rd_o=32'h2`, `tx_o=1` held for 20 cycles.
2. Store 0xA5 to BASE+0, sampling `tx_o` at mid-bit → 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1. STATUS reads busy=1 during the frame and returns to 32'h2 exactly 40 cycles after the pop.
3. Store 6 bytes 0x01..0x06 on consecutive cycles:
   - First byte is popped; bytes 2–5 fill the FIFO.
   - 6th is dropped; STATUS reads count=4, full=1, ovf=1 (32'h4D).
   - Five frames 0x01..0x05 come out contiguously over 200 cycles with no gaps.
4. Store `wd_i=32'h8` to BASE+4 → ovf clears; STATUS bit 3 = 0. Then a simultaneous clear and overflowing push leaves ovf=1.
5. Start a frame with 2 bytes queued, pull `reset` low mid-DATA → `tx_o=1` before the next clock edge. After release, STATUS reads 32'h2; a new store of 0x3C transmits correctly.
6. Store 0xFF to BASE_ADDR+16 and read it back → no frame starts, STATUS unchanged, and the read returns `rd_o=0`.
